// File: rtl/mem_pkg.sv
// Shared definitions for the two-requester memory arbiter: default widths,
// FSM state encoding and requester IDs.
package mem_pkg;

  localparam int unsigned AW_DEFAULT = 12;
  localparam int unsigned DW_DEFAULT = 8;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StCmd    = 2'd1;
  localparam logic [1:0] StRdwait = 2'd2;
  localparam logic [1:0] StRdcap  = 2'd3;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bundle for mem_arbiter; slave is the arbiter's
// view, master is the view of whatever drives requests and models the memory.
interface mem_arbiter_if
  import mem_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT,
  parameter int unsigned DW = DW_DEFAULT
);
  logic          req_a, req_b;
  logic          we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b;
  logic          rvalid_a, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          cen, rd, wr;
  logic [AW-1:0] add;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          busy;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, dout,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, cen, rd, wr, add, din, busy
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, dout,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, cen, rd, wr, add, din, busy
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the side
// not granted last. The pointer moves only when the caller commits a grant.
module rr_arb2
  import mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_update,
  output logic o_win,
  output logic o_any
);
  logic r_last;

  always_comb begin
    o_any = i_req_a | i_req_b;
    if (i_req_a && i_req_b) begin
      o_win = (r_last == REQ_A) ? REQ_B : REQ_A;
    end else begin
      o_win = i_req_b ? REQ_B : REQ_A;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= REQ_B;
    end else if (i_update) begin
      r_last <= o_win;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single-port synchronous memory; every
// output is registered from next-state values so it lines up with the FSM.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT,
  parameter int unsigned DW = DW_DEFAULT
)
(
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  logic [1:0]    r_state, w_state_d;
  logic          r_we, r_id;
  logic          w_win, w_any, w_enter;
  logic          w_we_sel;
  logic [AW-1:0] w_addr_sel;
  logic [DW-1:0] w_wdata_sel;

  logic          r_cen, r_rd, r_wr, r_busy;
  logic          r_gnt_a, r_gnt_b, r_rvalid_a, r_rvalid_b;
  logic [AW-1:0] r_add;
  logic [DW-1:0] r_din, r_rdata_a, r_rdata_b;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .i_req_a  (bus.req_a),
    .i_req_b  (bus.req_b),
    .i_update (w_enter),
    .o_win    (w_win),
    .o_any    (w_any)
  );

  always_comb begin
    w_we_sel    = (w_win == REQ_B) ? bus.we_b    : bus.we_a;
    w_addr_sel  = (w_win == REQ_B) ? bus.addr_b  : bus.addr_a;
    w_wdata_sel = (w_win == REQ_B) ? bus.wdata_b : bus.wdata_a;
    w_state_d   = r_state;
    w_enter     = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_any) begin
          w_state_d = StCmd;
          w_enter   = 1'b1;
        end
      end
      StCmd:    w_state_d = r_we ? StIdle : StRdwait;
      StRdwait: w_state_d = StRdcap;
      StRdcap:  w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_we       <= 1'b0;
      r_id       <= REQ_A;
      r_cen      <= 1'b1;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_busy     <= 1'b0;
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_add      <= '0;
      r_din      <= '0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_busy     <= (w_state_d != StIdle);
      r_cen      <= ~w_enter;
      r_rd       <= w_enter & ~w_we_sel;
      r_wr       <= w_enter & w_we_sel;
      r_gnt_a    <= w_enter & (w_win == REQ_A);
      r_gnt_b    <= w_enter & (w_win == REQ_B);
      r_rvalid_a <= (r_state == StRdwait) && (r_id == REQ_A);
      r_rvalid_b <= (r_state == StRdwait) && (r_id == REQ_B);
      // The registered address/data double as the captured command.
      if (w_enter) begin
        r_we  <= w_we_sel;
        r_id  <= w_win;
        r_add <= w_addr_sel;
        r_din <= w_wdata_sel;
      end
      if (r_state == StRdwait) begin
        if (r_id == REQ_A) begin
          r_rdata_a <= bus.dout;
        end else begin
          r_rdata_b <= bus.dout;
        end
      end
    end
  end

  assign bus.cen      = r_cen;
  assign bus.rd       = r_rd;
  assign bus.wr       = r_wr;
  assign bus.add      = r_add;
  assign bus.din      = r_din;
  assign bus.busy     = r_busy;
  assign bus.gnt_a    = r_gnt_a;
  assign bus.gnt_b    = r_gnt_b;
  assign bus.rvalid_a = r_rvalid_a;
  assign bus.rvalid_b = r_rvalid_b;
  assign bus.rdata_a  = r_rdata_a;
  assign bus.rdata_b  = r_rdata_b;
endmodule
